muladd_load_sequencer: RTL and testbench
========================================

Name: muladd_load_sequencer

Overview:
Hardware source for the MulAdd accelerator load stream. Fetches the Input vector and the eight Weight matrices from an external 16-bit dual-read-port buffer, packs two elements per beat, and drives load_en/load_payload into MulAdd_top with the exact beat ordering and inter-phase gaps that MulAdd_top expects. Sits between the host-loaded operand buffer and MulAdd_top on the clk_data domain.

Parameters:
DATA_W, 16, element width
ADDR_W, 12, buffer address width (Input at 0..255, Weight[j] at 256*(j+1)..256*(j+1)+255)
ROW, 16, row/column length of a 16x16 tile
NUM_LAYERS, 8, weight layers (layer 0 interleaved with Input, layers 1..7 standalone)
GAP_CYCLES, 24, idle cycles between consecutive phases

Ports:
clk_data  in  1  data clock
rst  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle pulse, begins a full load sequence; ignored unless idle
busy_o  out  1  high from start acceptance until done_o
done_o  out  1  one-cycle pulse after the last beat
rd_en_o  out  1  buffer read strobe (both ports)
rd_addr_hi_o  out  ADDR_W  port A address (upper half of beat)
rd_addr_lo_o  out  ADDR_W  port B address (lower half of beat)
rd_data_hi_i  in  DATA_W  port A data, valid 1 cycle after rd_en_o
rd_data_lo_i  in  DATA_W  port B data, valid 1 cycle after rd_en_o
load_en_o  out  1  beat valid to MulAdd_top
load_payload_o  out  2*DATA_W  {hi, lo} packed beat

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-sequence aborts immediately. No done_o is produced. Next start restarts from beat 0.
- FSM: IDLE -> PH0 on start_i. PH0 -> GAP after 256 beats. GAP -> LAYER after GAP_CYCLES. LAYER -> GAP after 128 beats while layer<7. LAYER -> FLUSH after layer 7. FLUSH (drain 2-cycle pipeline) -> IDLE with done_o.
- Counters: k (group), i (1..8, beat within group), layer (1..7), gap count.
- PH0 addressing, k=0..31, i=1..8:
  - k even, r=k/2: hi = 16r+17-2i, lo = hi-1.
  - k odd, c=(k-1)/2: hi = 256+(17-2i)*16+c, lo = 256+(16-2i)*16+c.
- LAYER L addressing, k=0..15, i=1..8, base=256*(L+1):
  - h=(k+2i-2) mod 16, l=(k+2i-1) mod 16.
  - hi = base+(18-2i)*16-h-1, lo = base+(17-2i)*16-l-1.
- Pipeline: rd_en_o/addresses are registered, updated on the edge that samples start_i (E0). Data returns at E1. load_en_o/load_payload_o are registered at E2. First beat is valid in the cycle after E2, i.e. 2-edge latency.
- Beats are contiguous within a phase. load_en_o is low for exactly GAP_CYCLES cycles between phases (7 gaps). Total active span is 1152 beats + 168 gap cycles = 1320 cycles.
- load_payload_o holds its last value when load_en_o=0.
- done_o fires in the cycle immediately after the last load_en_o beat. busy_o drops in that same cycle.
- start_i while busy is ignored. start_i coincident with done_o is ignored. start_i in the cycle after done_o is accepted.
- No backpressure: MulAdd_top always accepts.

Decomposition:
- muladd_pkg holds:
  - the DATA_W/ADDR_W/ROW/GAP_CYCLES constants;
  - the state enum (IDLE, PH0, GAP, LAYER, FLUSH);
  - INPUT_BASE and the WEIGHT_BASE(j) function.
- One sub-module, muladd_addr_gen: combinational address generator from (phase, layer, k, i) to (hi, lo). It is unit-testable against the formulas above.

Test Plan:
- Buffer preloaded mem[a]=a; pulse start -> first beat 2 edges later = 0x000F_000E. Beat 7 = 0x0001_0000. Beat 8 = 0x01F0_01E0.
- Same preload; capture the full stream:
  - exactly 1152 beats, 7 gaps of exactly 24 low cycles;
  - first layer-1 beat = 0x02FF_02EE;
  - last beat = 0x0812_0801;
  - done_o exactly one cycle later.
- Pulse start_i at beats 10 and 500 -> stream identical to the previous run, no restart.
- Assert rst for 1 cycle at beat 300 -> all outputs 0 asynchronously, no done_o. Subsequent start -> fresh stream beginning 0x000F_000E.
- Random buffer contents vs. golden model of the MulAdd_top load ordering -> every beat matches. Back-to-back start the cycle after done_o is accepted.

Source files
------------

// File: rtl/muladd_load_sequencer_pkg.sv
// Shared constants, FSM state type and buffer base-address helpers for the
// MulAdd load sequencer.
package muladd_load_sequencer_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned ROW        = 16;
    localparam int unsigned NUM_LAYERS = 8;
    localparam int unsigned GAP_CYCLES = 24;

    localparam int unsigned BEATS_PER_GROUP = ROW / 2;
    localparam int unsigned PH0_GROUPS      = 2 * ROW;
    localparam int unsigned LAYER_GROUPS    = ROW;
    localparam int unsigned FLUSH_CYCLES    = 2;

    localparam int unsigned K_W     = 5;
    localparam int unsigned I_W     = 4;
    localparam int unsigned LAYER_W = 3;
    localparam int unsigned CNT_W   = 5;

    localparam int unsigned INPUT_BASE = 0;

    typedef enum logic [2:0] {StIdle, StPh0, StGap, StLayer, StFlush} state_e;

    function automatic int unsigned WEIGHT_BASE(input int unsigned j);
        return ROW * ROW * (j + 1);
    endfunction

endpackage

// File: rtl/muladd_load_sequencer_if.sv
// Operand-buffer read port and MulAdd_top load port, driven by the sequencer.
interface muladd_load_sequencer_if;
    import muladd_load_sequencer_pkg::*;

    logic                  rd_en_o;
    logic [ADDR_W-1:0]     rd_addr_hi_o;
    logic [ADDR_W-1:0]     rd_addr_lo_o;
    logic [DATA_W-1:0]     rd_data_hi_i;
    logic [DATA_W-1:0]     rd_data_lo_i;
    logic                  load_en_o;
    logic [2*DATA_W-1:0]   load_payload_o;

    modport master (
        output rd_en_o, rd_addr_hi_o, rd_addr_lo_o, load_en_o, load_payload_o,
        input  rd_data_hi_i, rd_data_lo_i
    );

    modport slave (
        input  rd_en_o, rd_addr_hi_o, rd_addr_lo_o, load_en_o, load_payload_o,
        output rd_data_hi_i, rd_data_lo_i
    );

endinterface

// File: rtl/muladd_load_sequencer_addr_gen.sv
// Combinational beat address generator: (phase, layer, k, i) -> (hi, lo) buffer addresses.
module muladd_load_sequencer_addr_gen
    import muladd_load_sequencer_pkg::*;
(
    input  logic               i_ph0,
    input  logic [LAYER_W-1:0] i_layer,
    input  logic [K_W-1:0]     i_k,
    input  logic [I_W-1:0]     i_i,
    output logic [ADDR_W-1:0]  o_hi,
    output logic [ADDR_W-1:0]  o_lo
);

    int unsigned w_k;
    int unsigned w_i;
    int unsigned w_half;
    int unsigned w_h;
    int unsigned w_l;
    int unsigned w_base;

    always_comb begin
        w_k    = 32'(i_k);
        w_i    = 32'(i_i);
        w_half = w_k >> 1;
        w_h    = (w_k + 2 * w_i - 2) % ROW;
        w_l    = (w_k + 2 * w_i - 1) % ROW;
        w_base = WEIGHT_BASE(32'(i_layer));
        if (i_ph0 && !i_k[0]) begin
            // Input rows walk downward, two elements per beat
            o_hi = ADDR_W'(INPUT_BASE + ROW * w_half + ROW + 1 - 2 * w_i);
            o_lo = ADDR_W'(INPUT_BASE + ROW * w_half + ROW - 2 * w_i);
        end else if (i_ph0) begin
            o_hi = ADDR_W'(WEIGHT_BASE(0) + (ROW + 1 - 2 * w_i) * ROW + w_half);
            o_lo = ADDR_W'(WEIGHT_BASE(0) + (ROW - 2 * w_i) * ROW + w_half);
        end else begin
            o_hi = ADDR_W'(w_base + (ROW + 2 - 2 * w_i) * ROW - w_h - 1);
            o_lo = ADDR_W'(w_base + (ROW + 1 - 2 * w_i) * ROW - w_l - 1);
        end
    end

endmodule

// File: rtl/muladd_load_sequencer.sv
// Streams Input plus eight Weight tiles from the operand buffer into MulAdd_top,
// two elements per beat, with fixed idle gaps between phases.
module muladd_load_sequencer
    import muladd_load_sequencer_pkg::*;
(
    input  logic                     clk_data,
    input  logic                     rst,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    muladd_load_sequencer_if.master  bus
);

    state_e               r_state, w_state_nxt;
    logic [K_W-1:0]       r_k, w_k_nxt, w_k;
    logic [I_W-1:0]       r_i, w_i_nxt, w_i;
    logic [LAYER_W-1:0]   r_layer, w_layer_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 w_issue, w_phase_end, w_done_nxt, w_ph0;
    logic                 r_rd_en, r_vld, r_load_en, r_done;
    logic [ADDR_W-1:0]    r_addr_hi, r_addr_lo, w_addr_hi, w_addr_lo;
    logic [2*DATA_W-1:0]  r_payload;

    // Idle issues beat 0 itself so the first read leaves on the start edge
    always_comb begin
        w_k = (r_state == StIdle) ? '0 : r_k;
        w_i = (r_state == StIdle) ? I_W'(1) : r_i;
    end

    muladd_load_sequencer_addr_gen u_addr_gen (
        .i_ph0   (w_ph0),
        .i_layer (r_layer),
        .i_k     (w_k),
        .i_i     (w_i),
        .o_hi    (w_addr_hi),
        .o_lo    (w_addr_lo)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_i_nxt     = r_i;
        w_layer_nxt = r_layer;
        w_cnt_nxt   = r_cnt;
        w_issue     = 1'b0;
        w_phase_end = 1'b0;
        w_done_nxt  = 1'b0;
        w_ph0       = (r_state != StLayer);
        unique case (r_state)
            StIdle: begin
                // r_done blocks a start that coincides with the done pulse
                if (start_i && !r_done) begin
                    w_issue     = 1'b1;
                    w_state_nxt = StPh0;
                end
            end
            StPh0: begin
                w_issue = 1'b1;
                if (r_k == K_W'(PH0_GROUPS - 1) && r_i == I_W'(BEATS_PER_GROUP)) begin
                    w_phase_end = 1'b1;
                    w_state_nxt = StGap;
                    w_layer_nxt = LAYER_W'(1);
                end
            end
            StGap: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = StLayer;
                    w_cnt_nxt   = '0;
                end
            end
            StLayer: begin
                w_issue = 1'b1;
                if (r_k == K_W'(LAYER_GROUPS - 1) && r_i == I_W'(BEATS_PER_GROUP)) begin
                    w_phase_end = 1'b1;
                    w_cnt_nxt   = '0;
                    if (r_layer == LAYER_W'(NUM_LAYERS - 1)) begin
                        w_state_nxt = StFlush;
                    end else begin
                        w_state_nxt = StGap;
                        w_layer_nxt = r_layer + 1'b1;
                    end
                end
            end
            StFlush: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(FLUSH_CYCLES)) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                    w_layer_nxt = '0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        if (w_issue) begin
            if (w_i == I_W'(BEATS_PER_GROUP)) begin
                w_i_nxt = I_W'(1);
                w_k_nxt = w_phase_end ? '0 : w_k + 1'b1;
            end else begin
                w_i_nxt = w_i + 1'b1;
                w_k_nxt = w_k;
            end
        end
    end

    always_ff @(posedge clk_data or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_k       <= '0;
            r_i       <= '0;
            r_layer   <= '0;
            r_cnt     <= '0;
            r_rd_en   <= 1'b0;
            r_addr_hi <= '0;
            r_addr_lo <= '0;
            r_vld     <= 1'b0;
            r_load_en <= 1'b0;
            r_payload <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_i       <= w_i_nxt;
            r_layer   <= w_layer_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_en   <= w_issue;
            if (w_issue) begin
                r_addr_hi <= w_addr_hi;
                r_addr_lo <= w_addr_lo;
            end
            r_vld     <= r_rd_en;
            r_load_en <= r_vld;
            if (r_vld) begin
                r_payload <= {bus.rd_data_hi_i, bus.rd_data_lo_i};
            end
            r_done    <= w_done_nxt;
        end
    end

    assign busy_o             = (r_state != StIdle);
    assign done_o             = r_done;
    assign bus.rd_en_o        = r_rd_en;
    assign bus.rd_addr_hi_o   = r_addr_hi;
    assign bus.rd_addr_lo_o   = r_addr_lo;
    assign bus.load_en_o      = r_load_en;
    assign bus.load_payload_o = r_payload;

endmodule

// File: tb/tb_muladd_load_sequencer.sv
// Bench for muladd_load_sequencer: buffer model, stream monitor and golden load ordering.
module tb_muladd_load_sequencer;
    import muladd_load_sequencer_pkg::*;

    localparam int BEATS_TOTAL = 1152;
    localparam int SPAN_TOTAL  = 1320;
    localparam int RUN_LIMIT   = 3000;

    logic clk = 1'b0;
    logic rst;
    logic start_i;
    logic busy_o;
    logic done_o;

    muladd_load_sequencer_if bus_if ();

    muladd_load_sequencer dut (
        .clk_data (clk),
        .rst      (rst),
        .start_i  (start_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:4095];

    // Dual-read-port buffer, data one cycle after the read strobe
    always @(posedge clk) begin
        if (bus_if.rd_en_o) begin
            bus_if.rd_data_hi_i <= mem[bus_if.rd_addr_hi_o];
            bus_if.rd_data_lo_i <= mem[bus_if.rd_addr_lo_o];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] cap_q [$];
    logic [31:0] exp_q [$];
    int          gaps_q [$];
    int          cyc = 0;
    int          low_run, first_beat_cyc, last_beat_cyc, done_cyc, done_cnt;
    bit          seen_beat;
    logic        busy_at_done;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus_if.load_en_o) begin
                if (seen_beat && low_run > 0) gaps_q.push_back(low_run);
                if (!seen_beat) first_beat_cyc = cyc;
                low_run   = 0;
                seen_beat = 1'b1;
                cap_q.push_back(bus_if.load_payload_o);
                last_beat_cyc = cyc;
            end else if (seen_beat) begin
                low_run++;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy_o;
            end
        end
    end

    task automatic mon_clear();
        cap_q.delete();
        gaps_q.delete();
        low_run        = 0;
        seen_beat      = 1'b0;
        first_beat_cyc = -1;
        last_beat_cyc  = -1;
        done_cyc       = -1;
        done_cnt       = 0;
        busy_at_done   = 1'b1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_busy"},    64'(busy_o), 64'd0);
        chk({pfx, "_done"},    64'(done_o), 64'd0);
        chk({pfx, "_rd_en"},   64'(bus_if.rd_en_o), 64'd0);
        chk({pfx, "_addr_hi"}, 64'(bus_if.rd_addr_hi_o), 64'd0);
        chk({pfx, "_addr_lo"}, 64'(bus_if.rd_addr_lo_o), 64'd0);
        chk({pfx, "_load_en"}, 64'(bus_if.load_en_o), 64'd0);
        chk({pfx, "_payload"}, 64'(bus_if.load_payload_o), 64'd0);
    endtask

    task automatic fill_identity();
        for (int a = 0; a < 4096; a++) mem[a] = DATA_W'(a);
    endtask

    task automatic fill_random();
        for (int a = 0; a < 4096; a++) mem[a] = DATA_W'($urandom);
    endtask

    // Golden MulAdd_top load ordering straight from the address formulas
    task automatic build_exp();
        int hi, lo, h, l, base;
        exp_q.delete();
        for (int k = 0; k < 32; k++) begin
            for (int i = 1; i <= 8; i++) begin
                if (k % 2 == 0) begin
                    hi = 16 * (k / 2) + 17 - 2 * i;
                    lo = hi - 1;
                end else begin
                    hi = 256 + (17 - 2 * i) * 16 + (k - 1) / 2;
                    lo = 256 + (16 - 2 * i) * 16 + (k - 1) / 2;
                end
                exp_q.push_back({mem[hi], mem[lo]});
            end
        end
        for (int lyr = 1; lyr <= 7; lyr++) begin
            base = 256 * (lyr + 1);
            for (int k = 0; k < 16; k++) begin
                for (int i = 1; i <= 8; i++) begin
                    h  = (k + 2 * i - 2) % 16;
                    l  = (k + 2 * i - 1) % 16;
                    hi = base + (18 - 2 * i) * 16 - h - 1;
                    lo = base + (17 - 2 * i) * 16 - l - 1;
                    exp_q.push_back({mem[hi], mem[lo]});
                end
            end
        end
    endtask

    task automatic check_stream(input string name);
        int nbad = 0;
        int gbad = 0;
        chk({name, "_beat_count"}, 64'(cap_q.size()), 64'(BEATS_TOTAL));
        for (int b = 0; b < cap_q.size() && b < exp_q.size(); b++) begin
            if (cap_q[b] !== exp_q[b]) nbad++;
        end
        chk({name, "_payload_diffs"}, 64'(nbad), 64'd0);
        chk({name, "_gap_count"}, 64'(gaps_q.size()), 64'd7);
        foreach (gaps_q[g]) if (gaps_q[g] != GAP_CYCLES) gbad++;
        chk({name, "_bad_gaps"}, 64'(gbad), 64'd0);
        chk({name, "_span"}, 64'(last_beat_cyc - first_beat_cyc + 1), 64'(SPAN_TOTAL));
        chk({name, "_done_latency"}, 64'(done_cyc - last_beat_cyc), 64'd1);
        chk({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < RUN_LIMIT && !seen; n++) begin
            @(negedge clk);
            seen = done_o;
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    // Starts a run, optionally re-pulses start or asserts reset at given beat counts
    task automatic run_with_events(input int pa, input int pb, input int rst_at,
                                   output bit got_done);
        int beats = 0;
        got_done = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        for (int n = 0; n < RUN_LIMIT; n++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (done_o) begin
                got_done = 1'b1;
                break;
            end
            if (bus_if.load_en_o) begin
                beats++;
                if (beats == pa || beats == pb) start_i = 1'b1;
                if (beats == rst_at) begin
                    rst = 1'b1;
                    #1;
                    chk_all_zero("mid_rst");
                    @(negedge clk);
                    rst = 1'b0;
                    break;
                end
            end
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit got;
        int n_ld;
        int n_dn;

        tbl[0]  = '{0,    32'h000F_000E};
        tbl[1]  = '{1,    32'h000D_000C};
        tbl[2]  = '{7,    32'h0001_0000};
        tbl[3]  = '{8,    32'h01F0_01E0};
        tbl[4]  = '{15,   32'h0110_0100};
        tbl[5]  = '{16,   32'h001F_001E};
        tbl[6]  = '{255,  32'h011F_010F};
        tbl[7]  = '{256,  32'h02FF_02EE};
        tbl[8]  = '{263,  32'h0211_0200};
        tbl[9]  = '{264,  32'h02FE_02ED};
        tbl[10] = '{384,  32'h03FF_03EE};
        tbl[11] = '{1151, 32'h0812_0801};

        rst     = 1'b1;
        start_i = 1'b0;
        mon_clear();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Identity buffer: latency, fixed beats and full stream
        fill_identity();
        build_exp();
        mon_clear();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("e0_rd_en",   64'(bus_if.rd_en_o), 64'd1);
        chk("e0_addr_hi", 64'(bus_if.rd_addr_hi_o), 64'd15);
        chk("e0_addr_lo", 64'(bus_if.rd_addr_lo_o), 64'd14);
        chk("e0_busy",    64'(busy_o), 64'd1);
        chk("e0_load_en", 64'(bus_if.load_en_o), 64'd0);
        @(negedge clk);
        chk("e1_load_en", 64'(bus_if.load_en_o), 64'd0);
        @(negedge clk);
        chk("e2_load_en", 64'(bus_if.load_en_o), 64'd1);
        chk("e2_payload", 64'(bus_if.load_payload_o), 64'h000F_000E);
        wait_done("ident");
        check_stream("ident");
        for (int t = 0; t < 12; t++) begin
            if (tbl[t].idx < cap_q.size())
                chk($sformatf("beat_%0d", tbl[t].idx), 64'(cap_q[tbl[t].idx]), 64'(tbl[t].exp));
            else
                chk($sformatf("beat_%0d", tbl[t].idx), 64'bx, 64'(tbl[t].exp));
        end
        @(negedge clk);
        chk("hold_payload", 64'(bus_if.load_payload_o), 64'h0812_0801);

        // Extra starts mid-run must not restart the stream
        mon_clear();
        run_with_events(10, 500, -1, got);
        chk("pulses_done_seen", 64'(got), 64'd1);
        check_stream("pulses");

        // Reset at beat 300 aborts with no done, next start is fresh
        mon_clear();
        run_with_events(-1, -1, 300, got);
        chk("rst_run_no_done", 64'(got), 64'd0);
        n_ld = 0;
        n_dn = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus_if.load_en_o) n_ld++;
            if (done_o) n_dn++;
        end
        chk("rst_quiet_beats", 64'(n_ld), 64'd0);
        chk("rst_quiet_done",  64'(n_dn), 64'd0);
        mon_clear();
        run_with_events(-1, -1, -1, got);
        chk("after_rst_done_seen", 64'(got), 64'd1);
        check_stream("after_rst");
        chk("after_rst_first", 64'(cap_q.size() > 0 ? cap_q[0] : 32'hx), 64'h000F_000E);

        // Random buffer; a start coinciding with done is ignored
        fill_random();
        build_exp();
        mon_clear();
        run_with_events(-1, -1, -1, got);
        chk("rand1_done_seen", 64'(got), 64'd1);
        check_stream("rand1");
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("coinc_busy",  64'(busy_o), 64'd0);
        chk("coinc_rd_en", 64'(bus_if.rd_en_o), 64'd0);
        repeat (4) @(negedge clk);
        chk("coinc_still_idle", 64'(busy_o), 64'd0);

        // Random buffer; start in the cycle after done is accepted
        fill_random();
        build_exp();
        mon_clear();
        run_with_events(-1, -1, -1, got);
        chk("rand2_done_seen", 64'(got), 64'd1);
        check_stream("rand2");
        fill_random();
        build_exp();
        mon_clear();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("b2b_busy",  64'(busy_o), 64'd1);
        chk("b2b_rd_en", 64'(bus_if.rd_en_o), 64'd1);
        wait_done("b2b");
        check_stream("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
